// File: rtl/i2c_slave_engine.sv
// I2C slave protocol engine: samples SCL/SDA on the system clock, detects
// START/STOP, matches the device address, keeps an auto-incrementing register
// pointer, strobes writes into the register file and shifts read data out.
module i2c_slave_engine #(
    parameter logic [6:0] DEV_ADDR = 7'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sdaOutLow,
    output logic [7:0] regAddr,
    output logic [7:0] regDataOut,
    output logic       regWriteEn,
    input  logic [7:0] regDataIn,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, DEV_RX, DEV_ACK, PTR_RX, PTR_ACK,
        WR_RX, WR_ACK, RD_TX, RD_ACKCHK, WAIT_STOP
    } state_t;

    logic       scl_m_q, scl_s_q, scl_p_q;
    logic       sda_m_q, sda_s_q, sda_p_q;
    logic       scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d, tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d, wdata_q, wdata_d;
    logic       wen_q, wen_d, sda_low_q, sda_low_d;
    logic       busy_q, busy_d, rw_q, rw_d, nack_q, nack_d;

    // Two-flop synchroniser plus one delay stage; flops idle high like the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {scl_m_q, scl_s_q, scl_p_q} <= 3'b111;
            {sda_m_q, sda_s_q, sda_p_q} <= 3'b111;
        end else begin
            {scl_m_q, scl_s_q, scl_p_q} <= {sclIn, scl_m_q, scl_s_q};
            {sda_m_q, sda_s_q, sda_p_q} <= {sdaIn, sda_m_q, sda_s_q};
        end
    end

    assign scl_rise = scl_s_q & ~scl_p_q;
    assign scl_fall = ~scl_s_q & scl_p_q;
    assign start_ev = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
    assign stop_ev  = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            ptr_q     <= 8'h00;
            wdata_q   <= 8'h00;
            wen_q     <= 1'b0;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            nack_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            sda_low_q <= sda_low_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            nack_q    <= nack_d;
        end
    end

    // Next-state logic; START/STOP take priority over every bus state
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        wdata_d   = wdata_q;
        wen_d     = 1'b0;
        sda_low_d = sda_low_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        nack_d    = nack_q;

        // pointer advances the cycle after a write strobe
        if (wen_q) ptr_d = ptr_q + 8'd1;

        if (start_ev) begin
            state_d   = DEV_RX;
            bit_cnt_d = 4'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_ev) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                DEV_RX, PTR_RX, WR_RX: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        rx_d      = {rx_q[6:0], sda_s_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == WR_RX && bit_cnt_q == 4'd7) begin
                            wdata_d = {rx_q[6:0], sda_s_q};
                            wen_d   = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == DEV_RX) begin
                            if (rx_q[7:1] == DEV_ADDR) begin
                                sda_low_d = 1'b1;
                                rw_d      = rx_q[0];
                                state_d   = DEV_ACK;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else if (state_q == PTR_RX) begin
                            ptr_d     = rx_q;
                            sda_low_d = 1'b1;
                            state_d   = PTR_ACK;
                        end else begin
                            sda_low_d = 1'b1;
                            state_d   = WR_ACK;
                        end
                    end
                end
                DEV_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            tx_d      = regDataIn;
                            sda_low_d = ~regDataIn[7];
                            ptr_d     = ptr_q + 8'd1;
                            state_d   = RD_TX;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = PTR_RX;
                        end
                    end
                end
                PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = WR_RX;
                    end
                end
                RD_TX: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = 4'd0;
                            nack_d    = 1'b1;
                            state_d   = RD_ACKCHK;
                        end else begin
                            tx_d      = {tx_q[6:0], 1'b0};
                            sda_low_d = ~tx_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACKCHK: begin
                    if (scl_rise) nack_d = sda_s_q;
                    if (scl_fall) begin
                        if (!nack_q) begin
                            tx_d      = regDataIn;
                            sda_low_d = ~regDataIn[7];
                            ptr_d     = ptr_q + 8'd1;
                            bit_cnt_d = 4'd0;
                            state_d   = RD_TX;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = WAIT_STOP;
                        end
                    end
                end
                default: sda_low_d = 1'b0;
            endcase
        end
    end

    assign sdaOutLow  = sda_low_q;
    assign regAddr    = ptr_q;
    assign regDataOut = wdata_q;
    assign regWriteEn = wen_q;
    assign busy       = busy_q;

endmodule
